gecko_mem_arbiter: RTL and testbench



---
 rtl/gecko_mem_arbiter_pkg.sv | 11 +
 rtl/gecko_mem_arb_tag_fifo.sv | 50 +++++
 rtl/gecko_mem_arbiter.sv | 129 ++++++++++++
 tb/tb_gecko_mem_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gecko_mem_arbiter_pkg.sv
// Shared types for the gecko data-memory arbiter: requester id and arbitration FSM states.
package gecko_mem_arbiter_pkg;
  localparam int GECKO_MEM_ARB_PORTS = 2;

  typedef logic [0:0] gecko_mem_arb_id_t;

  typedef enum logic {
    GECKO_MEM_ARB_ARB,
    GECKO_MEM_ARB_HOLD
  } gecko_mem_arb_state_t;
endpackage

// File: rtl/gecko_mem_arb_tag_fifo.sv
// In-order FIFO of requester ids for reads in flight; head selects the response destination.
module gecko_mem_arb_tag_fifo
  import gecko_mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  gecko_mem_arb_id_t push_id,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output gecko_mem_arb_id_t head
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  gecko_mem_arb_id_t tag_q [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = tag_q[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Pointers are exactly clog2(DEPTH) wide, so they wrap by overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) tag_q[wr_ptr] <= push_id;
  end
endmodule

// File: rtl/gecko_mem_arbiter.sv
// Two-port data-memory arbiter with read-response routing via an in-order tag FIFO.
// Define GECKO_MEM_ARB_PRIORITY_EN for fixed priority (port 0 first); default is round-robin.
module gecko_mem_arbiter
  import gecko_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic                    req0_read_enable,
  input  logic [DATA_WIDTH/8-1:0] req0_write_enable,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic [DATA_WIDTH-1:0]   req0_data,
  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic                    req1_read_enable,
  input  logic [DATA_WIDTH/8-1:0] req1_write_enable,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic [DATA_WIDTH-1:0]   req1_data,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic                    mem_read_enable,
  output logic [DATA_WIDTH/8-1:0] mem_write_enable,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_data,
  input  logic                    mem_resp_valid,
  output logic                    mem_resp_ready,
  input  logic [DATA_WIDTH-1:0]   mem_resp_data,
  output logic                    resp0_valid,
  input  logic                    resp0_ready,
  output logic [DATA_WIDTH-1:0]   resp0_data,
  output logic                    resp1_valid,
  input  logic                    resp1_ready,
  output logic [DATA_WIDTH-1:0]   resp1_data,
  output logic                    orphan_resp
);
  localparam int NP = GECKO_MEM_ARB_PORTS;
  localparam int MW = DATA_WIDTH / 8;

  logic [NP-1:0]                 req_valid, req_rd, elig, req_ready, resp_valid, resp_ready;
  logic [NP-1:0][MW-1:0]         req_we;
  logic [NP-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NP-1:0][DATA_WIDTH-1:0] req_data;

  gecko_mem_arb_state_t state_q, state_d;
  gecko_mem_arb_id_t    rr_last_q, lock_id_q, win, head;
  logic                 tag_full, tag_empty, hs, push, pop, orphan_q;

  assign req_valid  = {req1_valid, req0_valid};
  assign req_rd     = {req1_read_enable, req0_read_enable};
  assign req_we     = {req1_write_enable, req0_write_enable};
  assign req_addr   = {req1_addr, req0_addr};
  assign req_data   = {req1_data, req0_data};
  assign resp_ready = {resp1_ready, resp0_ready};

  // Reads need a free tag slot; writes never wait on the FIFO.
  for (genvar p = 0; p < NP; p++) begin : g_port
    assign elig[p]       = req_valid[p] & (~req_rd[p] | ~tag_full);
    assign req_ready[p]  = hs & (win == gecko_mem_arb_id_t'(p));
    assign resp_valid[p] = ~rst & ~tag_empty & mem_resp_valid & (head == gecko_mem_arb_id_t'(p));
  end

  always_comb begin
    state_d   = state_q;
    win       = lock_id_q;
    mem_valid = 1'b0;
    if (state_q == GECKO_MEM_ARB_HOLD) begin
      mem_valid = req_valid[lock_id_q];
      if (!req_valid[lock_id_q] || mem_ready) state_d = GECKO_MEM_ARB_ARB;
    end else begin
`ifdef GECKO_MEM_ARB_PRIORITY_EN
      win = elig[0] ? 1'b0 : 1'b1;
`else
      win = (&elig) ? ~rr_last_q : elig[1];
`endif
      mem_valid = |elig;
      if (mem_valid && !mem_ready) state_d = GECKO_MEM_ARB_HOLD;
    end
    mem_valid = mem_valid & ~rst;
  end

  assign hs               = mem_valid & mem_ready;
  assign mem_read_enable  = req_rd[win];
  assign mem_write_enable = req_we[win];
  assign mem_addr         = req_addr[win];
  assign mem_data         = req_data[win];
  assign req0_ready       = req_ready[0];
  assign req1_ready       = req_ready[1];

  // With no tag outstanding the response has no owner: sink it and flag it.
  assign mem_resp_ready = ~rst & (tag_empty | resp_ready[head]);
  assign resp0_valid    = resp_valid[0];
  assign resp1_valid    = resp_valid[1];
  assign resp0_data     = mem_resp_data;
  assign resp1_data     = mem_resp_data;
  assign orphan_resp    = orphan_q;

  assign push = hs & mem_read_enable;
  assign pop  = mem_resp_valid & mem_resp_ready & ~tag_empty;

  gecko_mem_arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .push_id (win),
    .pop     (pop),
    .full    (tag_full),
    .empty   (tag_empty),
    .head    (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= GECKO_MEM_ARB_ARB;
      rr_last_q <= 1'b1;
      lock_id_q <= 1'b0;
      orphan_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (hs) rr_last_q <= win;
      if (state_q == GECKO_MEM_ARB_ARB) lock_id_q <= win;
      if (mem_resp_valid && tag_empty) orphan_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_gecko_mem_arbiter.sv
// Self-checking bench for gecko_mem_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_gecko_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid, req0_ready, req0_read_enable;
  logic [3:0]  req0_write_enable;
  logic [31:0] req0_addr, req0_data;
  logic        req1_valid, req1_ready, req1_read_enable;
  logic [3:0]  req1_write_enable;
  logic [31:0] req1_addr, req1_data;
  logic        mem_valid, mem_ready, mem_read_enable;
  logic [3:0]  mem_write_enable;
  logic [31:0] mem_addr, mem_data;
  logic        mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_resp_data;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [31:0] resp0_data, resp1_data;
  logic        orphan_resp;

  int errs = 0;
  int checks = 0;

  gecko_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_read_enable(req0_read_enable),
    .req0_write_enable(req0_write_enable), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_read_enable(req1_read_enable),
    .req1_write_enable(req1_write_enable), .req1_addr(req1_addr), .req1_data(req1_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready), .resp0_data(resp0_data),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready), .resp1_data(resp1_data),
    .orphan_resp(orphan_resp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  // Inputs change 1 time unit after posedge; outputs are sampled at negedge.
  task automatic adv(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  task automatic idle();
    req0_valid = 0; req0_read_enable = 0; req0_write_enable = 0; req0_addr = 0; req0_data = 0;
    req1_valid = 0; req1_read_enable = 0; req1_write_enable = 0; req1_addr = 0; req1_data = 0;
    mem_ready = 0; mem_resp_valid = 0; mem_resp_data = 0; resp0_ready = 0; resp1_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    adv(); adv();
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    adv();
    req0_valid = 1; req1_valid = 1; mem_ready = 1; mem_resp_valid = 1;
    resp0_ready = 1; resp1_ready = 1;
    smp();
    checks++;
    if ({mem_valid, req0_ready, req1_ready, resp0_valid, resp1_valid, mem_resp_ready, orphan_resp} !== 7'b0) begin
      errs++;
      $display("FAIL reset_outputs got=%b exp=0000000",
               {mem_valid, req0_ready, req1_ready, resp0_valid, resp1_valid, mem_resp_ready, orphan_resp});
    end
    adv();
    idle();
    rst = 0;
    smp();
    checks++;
    if (orphan_resp !== 1'b0) begin errs++; $display("FAIL reset_orphan got=%b exp=0", orphan_resp); end
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    do_reset();
    req0_valid = 1; req0_write_enable = 4'hF; req0_addr = 32'h40; req0_data = 32'h1111;
    req1_valid = 1; req1_write_enable = 4'hF; req1_addr = 32'h80; req1_data = 32'h2222;
    mem_ready = 1;
    for (int k = 0; k < 4; k++) begin
      smp();
`ifdef GECKO_MEM_ARB_PRIORITY_EN
      exp = 2'b01;
`else
      exp = (k % 2 == 0) ? 2'b01 : 2'b10;
`endif
      checks++;
      if ({req1_ready, req0_ready} !== exp || mem_addr !== (exp[0] ? 32'h40 : 32'h80)) begin
        errs++;
        $display("FAIL contention_%0d got ready=%b addr=%h exp ready=%b", k, {req1_ready, req0_ready}, mem_addr, exp);
      end
      adv();
    end
  endtask

  task automatic test_hold();
    do_reset();
    req1_valid = 1; req1_read_enable = 1; req1_addr = 32'h100;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin req0_valid = 1; req0_write_enable = 4'hF; req0_addr = 32'h200; end
      smp();
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h100 || req1_ready !== 1'b0 || req0_ready !== 1'b0) begin
        errs++;
        $display("FAIL hold_stall_%0d got valid=%b addr=%h r0=%b r1=%b exp 1 100 0 0", k, mem_valid, mem_addr, req0_ready, req1_ready);
      end
      adv();
    end
    mem_ready = 1;
    smp();
    checks++;
    if (mem_addr !== 32'h100 || req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errs++;
      $display("FAIL hold_release got addr=%h r0=%b r1=%b exp 100 0 1", mem_addr, req0_ready, req1_ready);
    end
    adv();
    req1_valid = 0;
    smp();
    checks++;
    if (mem_addr !== 32'h200 || req0_ready !== 1'b1) begin
      errs++;
      $display("FAIL hold_next got addr=%h r0=%b exp 200 1", mem_addr, req0_ready);
    end
    adv();
  endtask

  task automatic test_routing();
    logic [31:0] rdat [3];
    logic [1:0]  rown [3];
    logic [31:0] got;
    rdat[0] = 32'hA; rdat[1] = 32'hB; rdat[2] = 32'hC;
    rown[0] = 2'b01; rown[1] = 2'b10; rown[2] = 2'b01;
    do_reset();
    mem_ready = 1;
    req0_valid = 1; req0_read_enable = 1; req0_addr = 32'h10;
    smp();
    checks++;
    if (req0_ready !== 1'b1 || mem_addr !== 32'h10) begin errs++; $display("FAIL route_req0a got r0=%b addr=%h exp 1 10", req0_ready, mem_addr); end
    adv();
    req0_valid = 0; req1_valid = 1; req1_read_enable = 1; req1_addr = 32'h20;
    smp();
    checks++;
    if (req1_ready !== 1'b1 || mem_addr !== 32'h20) begin errs++; $display("FAIL route_req1 got r1=%b addr=%h exp 1 20", req1_ready, mem_addr); end
    adv();
    req1_valid = 0; req0_valid = 1; req0_addr = 32'h30;
    smp();
    checks++;
    if (req0_ready !== 1'b1 || mem_addr !== 32'h30) begin errs++; $display("FAIL route_req0b got r0=%b addr=%h exp 1 30", req0_ready, mem_addr); end
    adv();
    idle();
    resp0_ready = 1; resp1_ready = 1;
    for (int k = 0; k < 3; k++) begin
      mem_resp_valid = 1; mem_resp_data = rdat[k];
      smp();
      got = rown[k][0] ? resp0_data : resp1_data;
      checks++;
      if ({resp1_valid, resp0_valid} !== rown[k] || got !== rdat[k] || mem_resp_ready !== 1'b1) begin
        errs++;
        $display("FAIL route_resp_%0d got v=%b data=%h rdy=%b exp v=%b data=%h rdy=1",
                 k, {resp1_valid, resp0_valid}, got, mem_resp_ready, rown[k], rdat[k]);
      end
      adv();
    end
    mem_resp_valid = 0;
  endtask

  task automatic test_full();
    do_reset();
    mem_ready = 1;
    req0_valid = 1; req0_read_enable = 1;
    for (int k = 0; k < 4; k++) begin
      req0_addr = 32'h1000 + 32'(k * 4);
      smp();
      checks++;
      if (req0_ready !== 1'b1) begin errs++; $display("FAIL full_fill_%0d got r0=%b exp 1", k, req0_ready); end
      adv();
    end
    req0_addr = 32'h2000;
    req1_valid = 1; req1_write_enable = 4'b0011; req1_addr = 32'h300; req1_data = 32'hDEAD;
    smp();
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1 || mem_write_enable !== 4'b0011 ||
        mem_addr !== 32'h300 || mem_read_enable !== 1'b0) begin
      errs++;
      $display("FAIL full_block got r0=%b r1=%b we=%b addr=%h rd=%b exp 0 1 0011 300 0",
               req0_ready, req1_ready, mem_write_enable, mem_addr, mem_read_enable);
    end
    adv();
    idle();
  endtask

  task automatic test_backpressure_orphan();
    do_reset();
    mem_ready = 1; req1_valid = 1; req1_read_enable = 1; req1_addr = 32'h50;
    adv();
    idle();
    mem_resp_valid = 1; mem_resp_data = 32'h55; resp0_ready = 1; resp1_ready = 0;
    for (int k = 0; k < 2; k++) begin
      smp();
      checks++;
      if (mem_resp_ready !== 1'b0 || resp1_valid !== 1'b1 || resp0_valid !== 1'b0) begin
        errs++;
        $display("FAIL bp_stall_%0d got rdy=%b v1=%b v0=%b exp 0 1 0", k, mem_resp_ready, resp1_valid, resp0_valid);
      end
      adv();
    end
    resp1_ready = 1;
    smp();
    checks++;
    if (mem_resp_ready !== 1'b1 || resp1_data !== 32'h55 || orphan_resp !== 1'b0) begin
      errs++;
      $display("FAIL bp_drain got rdy=%b data=%h orphan=%b exp 1 55 0", mem_resp_ready, resp1_data, orphan_resp);
    end
    adv();
    mem_resp_data = 32'h66;
    smp();
    checks++;
    if (mem_resp_ready !== 1'b1 || resp0_valid !== 1'b0 || resp1_valid !== 1'b0) begin
      errs++;
      $display("FAIL orphan_sink got rdy=%b v0=%b v1=%b exp 1 0 0", mem_resp_ready, resp0_valid, resp1_valid);
    end
    adv();
    mem_resp_valid = 0;
    for (int k = 0; k < 2; k++) begin
      smp();
      checks++;
      if (orphan_resp !== 1'b1) begin errs++; $display("FAIL orphan_sticky_%0d got=%b exp=1", k, orphan_resp); end
      adv();
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    mem_ready = 1; req0_valid = 1; req0_read_enable = 1; req0_addr = 32'h8;
    adv();
    req0_valid = 0; req1_valid = 1; req1_read_enable = 1; req1_addr = 32'hC;
    adv();
    req1_addr = 32'h400; mem_ready = 0;
    adv();
    #2 rst = 1;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || req1_ready !== 1'b0) begin
      errs++;
      $display("FAIL midrst_async got valid=%b r1=%b exp 0 0", mem_valid, req1_ready);
    end
    adv();
    rst = 0;
    req0_valid = 1; req0_read_enable = 0; req0_write_enable = 4'hF; req0_addr = 32'h500;
    req1_read_enable = 0; req1_write_enable = 4'hF;
    mem_ready = 1; mem_resp_valid = 1; resp0_ready = 0; resp1_ready = 0;
    smp();
    checks++;
    if ({req1_ready, req0_ready, mem_resp_ready, resp1_valid, resp0_valid} !== 5'b01100) begin
      errs++;
      $display("FAIL midrst_after got r1r0=%b rdy=%b v1v0=%b exp 01 1 00",
               {req1_ready, req0_ready}, mem_resp_ready, {resp1_valid, resp0_valid});
    end
    adv();
    idle();
    smp();
    checks++;
    if (orphan_resp !== 1'b1) begin errs++; $display("FAIL midrst_orphan got=%b exp=1", orphan_resp); end
  endtask

  // Random traffic; requesters hold each request until granted.
  task automatic test_random();
    bit          pv [2], prd [2], m_rr, m_lock, m_lid, m_orph, win, mv, full, emp, h, hs;
    bit          el [2], rv, rr [2], e_mrr, e_v [2];
    bit          m_q [$];
    logic [3:0]  pwe [2];
    logic [31:0] paddr [2], pdata [2];
    logic [6:0]  got_c, exp_c;
    do_reset();
    m_rr = 1; m_lock = 0; m_lid = 0; m_orph = 0; m_q = {};
    pv[0] = 0; pv[1] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pv[p] && $urandom_range(0, 3) != 0) begin
          pv[p]    = 1;
          prd[p]   = ($urandom_range(0, 2) != 0);
          pwe[p]   = prd[p] ? 4'($urandom) : (4'($urandom) | 4'b0001);
          paddr[p] = $urandom;
          pdata[p] = $urandom;
        end
      end
      req0_valid = pv[0]; req0_read_enable = prd[0]; req0_write_enable = pwe[0];
      req0_addr = paddr[0]; req0_data = pdata[0];
      req1_valid = pv[1]; req1_read_enable = prd[1]; req1_write_enable = pwe[1];
      req1_addr = paddr[1]; req1_data = pdata[1];
      mem_ready = ($urandom_range(0, 2) != 0);
      rv = ($urandom_range(0, 2) == 0);
      mem_resp_valid = rv; mem_resp_data = $urandom;
      rr[0] = ($urandom_range(0, 3) != 0); rr[1] = ($urandom_range(0, 3) != 0);
      resp0_ready = rr[0]; resp1_ready = rr[1];

      full  = (m_q.size() == 4);
      el[0] = pv[0] && (!prd[0] || !full);
      el[1] = pv[1] && (!prd[1] || !full);
      if (m_lock) begin
        win = m_lid; mv = pv[m_lid];
      end else begin
`ifdef GECKO_MEM_ARB_PRIORITY_EN
        win = el[0] ? 1'b0 : 1'b1;
`else
        win = (el[0] && el[1]) ? !m_rr : el[1];
`endif
        mv = el[0] || el[1];
      end
      hs     = mv && mem_ready;
      emp    = (m_q.size() == 0);
      h      = emp ? 1'b0 : m_q[0];
      e_v[0] = !emp && h == 0 && rv;
      e_v[1] = !emp && h == 1 && rv;
      e_mrr  = emp || rr[h];
      exp_c  = {mv, hs && win == 1, hs && win == 0, e_mrr, e_v[1], e_v[0], m_orph};

      smp();
      got_c = {mem_valid, req1_ready, req0_ready, mem_resp_ready, resp1_valid, resp0_valid, orphan_resp};
      checks++;
      if (got_c !== exp_c) begin
        errs++;
        $display("FAIL rand_ctl_%0d got=%b exp=%b", c, got_c, exp_c);
      end
      if (mv) begin
        checks++;
        if ({mem_addr, mem_data, mem_write_enable, mem_read_enable} !== {paddr[win], pdata[win], pwe[win], prd[win]}) begin
          errs++;
          $display("FAIL rand_fields_%0d got addr=%h data=%h we=%b rd=%b exp port%0d addr=%h",
                   c, mem_addr, mem_data, mem_write_enable, mem_read_enable, win, paddr[win]);
        end
      end
      if (!emp && rv) begin
        checks++;
        if ((h ? resp1_data : resp0_data) !== mem_resp_data) begin
          errs++;
          $display("FAIL rand_rdata_%0d got=%h exp=%h", c, h ? resp1_data : resp0_data, mem_resp_data);
        end
      end

      if (rv && emp) m_orph = 1;
      if (rv && e_mrr && !emp) void'(m_q.pop_front());
      if (hs) begin
        m_rr = win; m_lock = 0;
        if (prd[win]) m_q.push_back(win);
        pv[win] = 0;
      end else if (mv) begin
        m_lock = 1; m_lid = win;
      end
      adv();
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_contention();
    test_hold();
    test_routing();
    test_full();
    test_backpressure_orphan();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
